// File: rtl/rio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rio_pkg
// Description : Shared position width and clamp helper for RIO input plugins.
// Revision    : 1.0 - initial release
// ============================================================================
package rio_pkg;

    localparam int POS_W = 32;

    // Limits a requested position to the top of the wiper range.
    function automatic logic [POS_W-1:0] clamp_pos(
        input logic [POS_W-1:0] i_val,
        input logic [POS_W-1:0] i_max
    );
        return (i_val > i_max) ? i_max : i_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : input_sync_filter
// Description : 2-FF synchronizer followed by a stability (debounce) filter.
// Revision    : 1.0 - initial release
// ============================================================================
module input_sync_filter #(
    parameter int FILTER = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_filt
);

    localparam int                c_cnt_w    = $clog2(FILTER + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_filt;
    logic [c_cnt_w-1:0] r_cnt;

    // The filtered value follows only after FILTER consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_filt  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/vin_udpoti.sv
`default_nettype none
// ============================================================================
// Module      : vin_udpoti
// Description : Up/down digital-pot pulse decoder producing a wiper position.
// Revision    : 1.0 - initial release
// ============================================================================
module vin_udpoti
    import rio_pkg::*;
#(
    parameter int RESOLUTION = 100,
    parameter int FILTER     = 16,
    parameter int TIMEOUT    = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             UPDOWN,
    input  logic             INCREMENT,
    input  logic             load,
    input  logic [POS_W-1:0] load_value,
    output logic [POS_W-1:0] value,
    output logic             step,
    output logic             dir,
    output logic             active
);

    localparam logic [POS_W-1:0]   c_res   = POS_W'(RESOLUTION);
    localparam int                 c_tmo_w = $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0] c_tmo   = c_tmo_w'(TIMEOUT);

    logic               w_ud_filt;
    logic               w_inc_filt;
    logic               r_inc_prev;
    logic               w_inc_fall;
    logic [POS_W-1:0]   r_value;
    logic               r_step;
    logic               r_dir;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic [POS_W-1:0]   w_next_value;
    logic               w_next_step;
    logic               w_next_dir;

    input_sync_filter #(.FILTER(FILTER)) u_ud_filter (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (UPDOWN),
        .o_filt (w_ud_filt)
    );

    input_sync_filter #(.FILTER(FILTER)) u_inc_filter (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (INCREMENT),
        .o_filt (w_inc_filt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inc_prev <= 1'b0;
        end else begin
            r_inc_prev <= w_inc_filt;
        end
    end

    assign w_inc_fall = r_inc_prev & ~w_inc_filt;

    // Saturated steps still record direction but leave the position alone.
    always_comb begin
        w_next_value = r_value;
        w_next_step  = 1'b0;
        w_next_dir   = r_dir;
        if (w_inc_fall) begin
            w_next_dir = w_ud_filt;
            if (w_ud_filt && (r_value < c_res)) begin
                w_next_value = r_value + 1'b1;
                w_next_step  = 1'b1;
            end else if (!w_ud_filt && (r_value != '0)) begin
                w_next_value = r_value - 1'b1;
                w_next_step  = 1'b1;
            end
        end
    end

    // A load wins over a coincident step, which is dropped entirely.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
        end else if (load) begin
            r_value <= clamp_pos(load_value, c_res);
            r_step  <= 1'b0;
        end else begin
            r_value <= w_next_value;
            r_step  <= w_next_step;
            r_dir   <= w_next_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_inc_fall) begin
            r_tmo_cnt <= c_tmo;
        end else if (r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
        end
    end

    assign value  = r_value;
    assign step   = r_step;
    assign dir    = r_dir;
    assign active = (r_tmo_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_vin_udpoti.sv
`default_nettype none
// ============================================================================
// Module      : tb_vin_udpoti
// Description : Directed, table-driven self-checking bench for vin_udpoti.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vin_udpoti;

    logic        clk = 1'b0;
    logic        reset;
    logic        UPDOWN;
    logic        INCREMENT;
    logic        load;
    logic [31:0] load_value;
    logic [31:0] value;
    logic        step;
    logic        dir;
    logic        active;

    int total = 0;
    int bad   = 0;
    int step_cnt = 0;
    int act_low_cnt = 0;
    bit mon_act = 1'b0;

    typedef struct {
        logic        load_en;
        logic [31:0] load_val;
        logic        ud;
        int          npulse;
        int          hi;
        logic [31:0] exp_value;
        int          exp_steps;
        logic        exp_dir;
        logic        chk_active;
    } vec_t;

    vec_t vecs[7];

    vin_udpoti #(.RESOLUTION(100), .FILTER(4), .TIMEOUT(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .UPDOWN     (UPDOWN),
        .INCREMENT  (INCREMENT),
        .load       (load),
        .load_value (load_value),
        .value      (value),
        .step       (step),
        .dir        (dir),
        .active     (active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step) step_cnt <= step_cnt + 1;
        if (mon_act && !active) act_low_cnt <= act_low_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [31:0] v);
        load = 1'b1;
        load_value = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse(input logic ud, input int hi, input int lo);
        UPDOWN = ud;
        INCREMENT = 1'b1;
        repeat (hi) @(negedge clk);
        INCREMENT = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int a0;
        int n;
        // {load_en, load_val, ud, npulse, hi, exp_value, exp_steps, exp_dir, chk_active}
        vecs[0] = '{1'b0, 32'd0,   1'b1,   9,  8, 32'd10,  9, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 32'd50,  1'b0, 100,  8, 32'd0,  50, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'd100, 1'b1,   3,  8, 32'd100, 0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'd250, 1'b1,   3,  8, 32'd100, 0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'd3,   1'b0,   2,  8, 32'd1,   2, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 32'd0,   1'b1,   1,  3, 32'd1,   0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'd0,   1'b1,   1, 10, 32'd2,   1, 1'b1, 1'b1};

        reset = 1'b1; UPDOWN = 1'b0; INCREMENT = 1'b0; load = 1'b0; load_value = '0;
        repeat (3) @(negedge clk);
        chk("reset_value", value, 0);
        chk("reset_step", {31'd0, step}, 0);
        chk("reset_dir", {31'd0, dir}, 0);
        chk("reset_active", {31'd0, active}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Latency from pin fall to value change is FILTER+3 = 7 cycles.
        UPDOWN = 1'b1; INCREMENT = 1'b1;
        repeat (8) @(negedge clk);
        INCREMENT = 1'b0;
        repeat (6) @(negedge clk);
        chk("latency_before", value, 0);
        @(negedge clk);
        chk("latency_value", value, 1);
        chk("latency_step", {31'd0, step}, 1);
        chk("latency_dir", {31'd0, dir}, 1);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            s0 = step_cnt;
            a0 = act_low_cnt;
            if (vecs[i].load_en) do_load(vecs[i].load_val);
            for (int p = 0; p < vecs[i].npulse; p++) begin
                pulse(vecs[i].ud, vecs[i].hi, 8);
                if (p == 0) mon_act = vecs[i].chk_active;
            end
            repeat (8) @(negedge clk);
            mon_act = 1'b0;
            chk($sformatf("vec%0d_value", i), value, vecs[i].exp_value);
            chk($sformatf("vec%0d_steps", i), step_cnt - s0, vecs[i].exp_steps);
            chk($sformatf("vec%0d_dir", i), {31'd0, dir}, {31'd0, vecs[i].exp_dir});
            if (vecs[i].chk_active)
                chk($sformatf("vec%0d_active_hold", i), act_low_cnt - a0, 0);
        end

        // Load in the inc_fall cycle wins and the step is dropped.
        do_load(32'd20);
        s0 = step_cnt;
        UPDOWN = 1'b1; INCREMENT = 1'b1;
        repeat (8) @(negedge clk);
        INCREMENT = 1'b0;
        repeat (6) @(negedge clk);
        load = 1'b1; load_value = 32'd7;
        @(negedge clk);
        load = 1'b0;
        chk("ldstep_value", value, 7);
        chk("ldstep_step", {31'd0, step}, 0);
        repeat (8) @(negedge clk);
        chk("ldstep_hold", value, 7);
        chk("ldstep_steps", step_cnt - s0, 0);
        pulse(1'b1, 8, 8);
        chk("ldstep_next", value, 8);

        // Active stays high for exactly TIMEOUT cycles after one step.
        repeat (30) @(negedge clk);
        chk("tmo_idle", {31'd0, active}, 0);
        UPDOWN = 1'b1; INCREMENT = 1'b1;
        repeat (8) @(negedge clk);
        INCREMENT = 1'b0;
        repeat (7) @(negedge clk);
        chk("tmo_rise", {31'd0, active}, 1);
        n = 0;
        while (active && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_len", n, 20);
        chk("tmo_value", value, 9);

        // Reset while the pin is high, pin released during reset: no step.
        do_load(32'd5);
        UPDOWN = 1'b1; INCREMENT = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        INCREMENT = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_value", value, 0);
        chk("rst_active", {31'd0, active}, 0);
        s0 = step_cnt;
        repeat (20) @(negedge clk);
        chk("rst_nostep_value", value, 0);
        chk("rst_nostep_steps", step_cnt - s0, 0);

        // Pin held high through reset steps only after a later fall.
        INCREMENT = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        s0 = step_cnt;
        repeat (10) @(negedge clk);
        chk("rsthi_high_value", value, 0);
        INCREMENT = 1'b0;
        repeat (10) @(negedge clk);
        chk("rsthi_fall_value", value, 1);
        chk("rsthi_fall_steps", step_cnt - s0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
